mem_arbiter: RTL and testbench



---
 rtl/sigma_mem_pkg.sv | 33 +++
 rtl/mem_arbiter_if.sv | 29 ++
 rtl/mem_arb_hold_counter.sv | 45 ++++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sigma_mem_pkg.sv
// Shared definitions for the main-memory arbiter: bus widths, requester ids,
// arbiter state encoding and the state-to-grant decode.
// Optional feature macro used by the arbiter: MEM_ARB_ROUND_ROBIN_EN.
package sigma_mem_pkg;

    localparam int ADDR_MSB = 15;
    localparam int ADDR_LSB = 31;
    localparam int ADDR_W   = ADDR_LSB - ADDR_MSB + 1;
    localparam int DATA_W   = 32;
    localparam int BE_W     = 4;
    localparam int CNT_W    = 8;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_IOP = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_e;

    // One-hot grant vector (bit 0 = CPU, bit 1 = IOP) for a given owner state.
    function automatic logic [0:1] grant_of(input arb_state_e st);
        logic [0:1] g;
        case (st)
            ST_OWN0: g = 2'b10;
            ST_OWN1: g = 2'b01;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
// Master modport is the environment (requesters + memory), slave is the arbiter.
// Optional feature macro used by the arbiter: MEM_ARB_ROUND_ROBIN_EN.
interface mem_arbiter_if;
    import sigma_mem_pkg::*;

    logic [0:1]               running;
    logic [0:1]               active;
    logic [ADDR_MSB:ADDR_LSB] address0;
    logic [ADDR_MSB:ADDR_LSB] address1;
    logic [0:DATA_W-1]        data_in0;
    logic [0:DATA_W-1]        data_in1;
    logic [0:BE_W-1]          write_en0;
    logic [0:BE_W-1]          write_en1;
    logic [ADDR_MSB:ADDR_LSB] mem_address;
    logic [0:DATA_W-1]        mem_data_in;
    logic [0:BE_W-1]          mem_write_en;

    modport master (
        output running, address0, address1, data_in0, data_in1, write_en0, write_en1,
        input  active, mem_address, mem_data_in, mem_write_en
    );

    modport slave (
        input  running, address0, address1, data_in0, data_in1, write_en0, write_en1,
        output active, mem_address, mem_data_in, mem_write_en
    );

endinterface

// File: rtl/mem_arb_hold_counter.sv
// Contended-ownership counter: counts owned cycles while the other requester
// waits and flags the last allowed cycle of a turn (count == MAX_HOLD-1).
// Optional feature macro used by the arbiter: MEM_ARB_ROUND_ROBIN_EN.
module mem_arb_hold_counter
    import sigma_mem_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear has priority, otherwise count only while contended.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (enable_i) begin
            count_d = count_q + ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (count_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester main-memory arbiter (CPU = requester 0, IOP = requester 1).
// Grants one owner at a time with a mandatory IDLE cycle on every handover,
// bounds contended ownership at MAX_HOLD cycles, and muxes the owner's
// address/data/byte enables onto the memory port (zeros while IDLE).
// Macro MEM_ARB_ROUND_ROBIN_EN: contention goes to the requester that did not
// own last; when undefined the IOP always wins contention.
module mem_arbiter
    import sigma_mem_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_owner_q;
    logic       last_owner_d;
    logic [0:1] active_q;
    logic       hold_clear_s;
    logic       hold_en_s;
    logic       hold_expired_s;

    // The turn counter only runs while the non-owner is waiting.
    always_comb begin
        hold_en_s = 1'b0;
        case (state_q)
            ST_OWN0: hold_en_s = bus.running[1];
            ST_OWN1: hold_en_s = bus.running[0];
            default: hold_en_s = 1'b0;
        endcase
    end

    assign hold_clear_s = (state_q == ST_IDLE);

    mem_arb_hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (hold_clear_s),
        .enable_i  (hold_en_s),
        .expired_o (hold_expired_s)
    );

    // State, last owner and registered grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_owner_q <= REQ_IOP;
            active_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            active_q     <= grant_of(state_d);
        end
    end

    // Next-state: every release goes through IDLE so enables never overlap.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            ST_IDLE: begin
                case (bus.running)
                    2'b10: state_d = ST_OWN0;
                    2'b01: state_d = ST_OWN1;
                    2'b11: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        if (last_owner_q == REQ_CPU) begin
                            state_d = ST_OWN1;
                        end else begin
                            state_d = ST_OWN0;
                        end
`else
                        state_d = ST_OWN1;
`endif
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_OWN0: begin
                if (!bus.running[0] || hold_expired_s) begin
                    state_d      = ST_IDLE;
                    last_owner_d = REQ_CPU;
                end else begin
                    state_d = ST_OWN0;
                end
            end
            ST_OWN1: begin
                if (!bus.running[1] || hold_expired_s) begin
                    state_d      = ST_IDLE;
                    last_owner_d = REQ_IOP;
                end else begin
                    state_d = ST_OWN1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory port mux on the registered state; IDLE drives all zeros.
    always_comb begin
        bus.mem_address  = {ADDR_W{1'b0}};
        bus.mem_data_in  = {DATA_W{1'b0}};
        bus.mem_write_en = {BE_W{1'b0}};
        case (state_q)
            ST_OWN0: begin
                bus.mem_address  = bus.address0;
                bus.mem_data_in  = bus.data_in0;
                bus.mem_write_en = bus.write_en0;
            end
            ST_OWN1: begin
                bus.mem_address  = bus.address1;
                bus.mem_data_in  = bus.data_in1;
                bus.mem_write_en = bus.write_en1;
            end
            default: begin
                bus.mem_address  = {ADDR_W{1'b0}};
                bus.mem_data_in  = {DATA_W{1'b0}};
                bus.mem_write_en = {BE_W{1'b0}};
            end
        endcase
    end

    assign bus.active = active_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a turn-based reference model and a
// byte-enable memory model fed from the arbiter's memory port.
// Follows MEM_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_arbiter;

    localparam int MAX_HOLD = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Reference model: owner (-1 none), contended cycles used this turn, last owner.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 1;

    always @(posedge clock) begin
        if (reset) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = 1;
        end else if (m_owner < 0) begin
            m_held = 0;
            if (bus.running[0] && bus.running[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                m_owner = 1 - m_last;
`else
                m_owner = 1;
`endif
            end else if (bus.running[0]) begin
                m_owner = 0;
            end else if (bus.running[1]) begin
                m_owner = 1;
            end
        end else begin
            if (!bus.running[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (bus.running[1 - m_owner]) begin
                m_held = m_held + 1;
                if (m_held == MAX_HOLD) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
    end

    // Memory array model: commits whatever the port shows at each edge.
    logic [0:31] mem_model [int];
    logic [0:31] wword;

    always @(posedge clock) begin
        if (bus.mem_write_en != 4'b0000) begin
            wword = mem_model.exists(int'(bus.mem_address)) ? mem_model[int'(bus.mem_address)] : 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_write_en[b]) wword[b*8 +: 8] = bus.mem_data_in[b*8 +: 8];
            end
            mem_model[int'(bus.mem_address)] = wword;
        end
    end

    function automatic logic [0:1] exp_active();
        if (m_owner == 0) return 2'b10;
        if (m_owner == 1) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [15:31] exp_addr();
        if (m_owner == 0) return bus.address0;
        if (m_owner == 1) return bus.address1;
        return 17'h0;
    endfunction

    function automatic logic [0:31] exp_data();
        if (m_owner == 0) return bus.data_in0;
        if (m_owner == 1) return bus.data_in1;
        return 32'h0;
    endfunction

    function automatic logic [0:3] exp_we();
        if (m_owner == 0) return bus.write_en0;
        if (m_owner == 1) return bus.write_en1;
        return 4'h0;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.running   = 2'b00;
        bus.address0  = 17'h1ABCD;
        bus.address1  = 17'h05555;
        bus.data_in0  = 32'hFFFFFFFF;
        bus.data_in1  = 32'h12345678;
        bus.write_en0 = 4'hF;
        bus.write_en1 = 4'hF;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.active !== 2'b00) begin
            errors++;
            $display("FAIL reset_active got %b want 00", bus.active);
        end
        checks++;
        if (bus.mem_address !== 17'h0 || bus.mem_data_in !== 32'h0 || bus.mem_write_en !== 4'h0) begin
            errors++;
            $display("FAIL reset_mem got addr %h data %h we %b want zeros",
                     bus.mem_address, bus.mem_data_in, bus.mem_write_en);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        do_reset();
        bus.running   = 2'b10;
        bus.address0  = 17'h00010;
        bus.data_in0  = 32'hDEADBEEF;
        bus.write_en0 = 4'hF;
        mem_model.delete(16);
        tick();
        checks++;
        if (bus.active !== 2'b10) begin
            errors++;
            $display("FAIL grant0_active got %b want 10", bus.active);
        end
        checks++;
        if (bus.mem_address !== 17'h00010 || bus.mem_write_en !== 4'hF || bus.mem_data_in !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL grant0_port got addr %h data %h we %b want 00010 deadbeef 1111",
                     bus.mem_address, bus.mem_data_in, bus.mem_write_en);
        end
        tick();
        checks++;
        if (!mem_model.exists(16) || mem_model[16] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write0_commit got %h want deadbeef", mem_model.exists(16) ? mem_model[16] : 32'h0);
        end
        bus.running   = 2'b00;
        bus.write_en0 = 4'h0;
        tick();
        checks++;
        if (bus.active !== 2'b00) begin
            errors++;
            $display("FAIL release0 got %b want 00", bus.active);
        end
    endtask

    task automatic test_req1_only();
        int owned;
        owned = 0;
        do_reset();
        bus.write_en1 = 4'b1010;
        bus.address1  = 17'h00123;
        bus.data_in1  = $urandom;
        bus.running   = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.active == 2'b01) owned++;
            checks++;
            if (bus.mem_write_en !== 4'b1010) begin
                errors++;
                $display("FAIL req1_we cycle %0d got %b want 1010", i, bus.mem_write_en);
            end
        end
        bus.running = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.active !== 2'b00 || bus.mem_write_en !== 4'b0000) begin
                errors++;
                $display("FAIL req1_idle cycle %0d got active %b we %b want 00 0000", i, bus.active, bus.mem_write_en);
            end
        end
        checks++;
        if (owned !== 5) begin
            errors++;
            $display("FAIL req1_owned_cycles got %0d want 5", owned);
        end
    endtask

    task automatic test_contention();
        logic [0:1] want;
        int         period;
        int         phase;
        int         turn;
        period = MAX_HOLD + 1;
        do_reset();
        bus.write_en0 = 4'b1100;
        bus.write_en1 = 4'b0011;
        bus.running   = 2'b11;
        for (int k = 0; k < 3 * period; k++) begin
            tick();
            phase = k % period;
            turn  = k / period;
            if (phase == MAX_HOLD) begin
                want = 2'b00;
            end else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                want = (turn % 2 == 0) ? 2'b10 : 2'b01;
`else
                want = 2'b01;
`endif
            end
            checks++;
            if (bus.active !== want) begin
                errors++;
                $display("FAIL contend_active cycle %0d got %b want %b", k, bus.active, want);
            end
            checks++;
            if (bus.mem_write_en !== (want == 2'b10 ? 4'b1100 : (want == 2'b01 ? 4'b0011 : 4'b0000))) begin
                errors++;
                $display("FAIL contend_we cycle %0d got %b for grant %b", k, bus.mem_write_en, want);
            end
        end
        bus.running = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [0:31] d;
        d = $urandom;
        do_reset();
        mem_model.delete(32);
        bus.running   = 2'b10;
        bus.address0  = 17'h00020;
        bus.data_in0  = d;
        bus.write_en0 = 4'hF;
        tick();
        checks++;
        if (bus.active !== 2'b10 || bus.mem_write_en !== 4'hF) begin
            errors++;
            $display("FAIL rstmid_pre got active %b we %b want 10 1111", bus.active, bus.mem_write_en);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (!mem_model.exists(32) || mem_model[32] !== d) begin
            errors++;
            $display("FAIL rstmid_commit got %h want %h", mem_model.exists(32) ? mem_model[32] : 32'h0, d);
        end
        checks++;
        if (bus.active !== 2'b00 || bus.mem_address !== 17'h0 || bus.mem_data_in !== 32'h0 || bus.mem_write_en !== 4'h0) begin
            errors++;
            $display("FAIL rstmid_outputs got active %b addr %h data %h we %b want zeros",
                     bus.active, bus.mem_address, bus.mem_data_in, bus.mem_write_en);
        end
        reset = 1'b0;
        bus.running = 2'b00;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.write_en0 = 4'b1100;
        bus.write_en1 = 4'b0011;
        bus.address0  = 17'h00040;
        bus.address1  = 17'h00041;
        bus.running   = 2'b10;
        tick();
        tick();
        bus.running = 2'b01;
        tick();
        checks++;
        if (bus.active !== 2'b00 || bus.mem_write_en !== 4'b0000) begin
            errors++;
            $display("FAIL handover_gap got active %b we %b want 00 0000", bus.active, bus.mem_write_en);
        end
        tick();
        checks++;
        if (bus.active !== 2'b01 || bus.mem_write_en !== 4'b0011 || bus.mem_address !== 17'h00041) begin
            errors++;
            $display("FAIL handover_grant got active %b we %b addr %h want 01 0011 00041",
                     bus.active, bus.mem_write_en, bus.mem_address);
        end
        bus.running = 2'b00;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) bus.running[0] = ~bus.running[0];
            if ($urandom_range(3) == 0) bus.running[1] = ~bus.running[1];
            bus.address0  = 17'($urandom);
            bus.address1  = 17'($urandom);
            bus.data_in0  = $urandom;
            bus.data_in1  = $urandom;
            bus.write_en0 = 4'($urandom);
            bus.write_en1 = 4'($urandom);
            reset = ($urandom_range(99) == 0);
            tick();
            checks++;
            if (bus.active !== exp_active()) begin
                errors++;
                $display("FAIL rand_active cycle %0d got %b want %b", i, bus.active, exp_active());
            end
            checks++;
            if (bus.mem_address !== exp_addr() || bus.mem_data_in !== exp_data() || bus.mem_write_en !== exp_we()) begin
                errors++;
                $display("FAIL rand_port cycle %0d got %h %h %b want %h %h %b", i,
                         bus.mem_address, bus.mem_data_in, bus.mem_write_en, exp_addr(), exp_data(), exp_we());
            end
        end
        reset = 1'b0;
        bus.running = 2'b00;
        tick();
    endtask

    initial begin
        bus.running   = 2'b00;
        bus.address0  = 17'h0;
        bus.address1  = 17'h0;
        bus.data_in0  = 32'h0;
        bus.data_in1  = 32'h0;
        bus.write_en0 = 4'h0;
        bus.write_en1 = 4'h0;
        test_reset();
        test_single_write();
        test_req1_only();
        test_contention();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
